// File: rtl/down_counter_pkg.sv
// Shared counter header for the down counter.
// Holds the terminal-count state encoding, the FSM state type and the
// saturate-at-zero select macro used by the decrement path.
// No ports: this file only provides definitions that the other files import.

`ifndef DC_SAT_ZERO
// Pick the zero value when the counter is already empty, otherwise the
// decremented value. The count never wraps from 0 to all-ones.
`define DC_SAT_ZERO(isZero, zeroVal, nextVal) ((isZero) ? (zeroVal) : (nextVal))
`endif

package down_counter_pkg;

    localparam logic [1:0] DC_IDLE    = 2'b00;
    localparam logic [1:0] DC_RUN     = 2'b01;
    localparam logic [1:0] DC_EXPIRED = 2'b10;

    // 2'b11 is deliberately left out; the FSM recovers from it to IDLE.
    typedef enum logic [1:0] {
        ST_IDLE    = DC_IDLE,
        ST_RUN     = DC_RUN,
        ST_EXPIRED = DC_EXPIRED
    } dc_state_e;

endpackage

// File: rtl/down_counter_adder.sv
// Plain WIDTH-bit adder. The down counter ties b_i to all-ones so that
// sum_o = a_i - 1 modulo 2^WIDTH; the carry-out is not kept.
// Ports:
//   a_i    first operand
//   b_i    second operand
//   sum_o  a_i + b_i truncated to WIDTH bits

module down_counter_adder #(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] sum_o
);

    assign sum_o = a_i + b_i;

endmodule

// File: rtl/down_counter_reg.sv
// Generic register with synchronous active-high reset to a fixed value.
// Used for the count register and the 2-bit FSM state register.
// Ports:
//   clk_i  rising-edge clock
//   rst_i  synchronous reset, active-high
//   d_i    next value
//   q_o    registered value

module down_counter_reg #(
    parameter int unsigned  W         = 1,
    parameter logic [W-1:0] RESET_VAL = '0
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            q_o <= RESET_VAL;
        end else begin
            q_o <= d_i;
        end
    end

endmodule

// File: rtl/down_counter.sv
// Loadable, saturating down counter with a terminal-count FSM.
// Loaded with a credit/countdown value, decremented once per consumed event,
// it raises a single expire pulse when a decrement takes it from 1 to 0.
// Ports:
//   clk_i       rising-edge clock
//   rst_i       synchronous reset, active-high
//   load_i      write load_val_i into the count and re-arm the FSM
//   load_val_i  value written by load_i
//   dec_i       decrement request
//   ack_i       clears the EXPIRED state
//   count_o     current count (registered)
//   busy_o      state is RUN
//   expired_o   state is EXPIRED
//   expire_o    one-cycle pulse on the first cycle count reads 0 after 1->0
//   dec_err_o   one-cycle pulse: dec_i arrived with count 0 and no load

module down_counter
    import down_counter_pkg::*;
#(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned RESET_VAL = 0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             dec_i,
    input  logic             ack_i,
    output logic [WIDTH-1:0] count_o,
    output logic             busy_o,
    output logic             expired_o,
    output logic             expire_o,
    output logic             dec_err_o
);

    localparam logic [WIDTH-1:0] RESET_COUNT = WIDTH'(RESET_VAL);
    localparam logic [1:0]       RESET_STATE = (RESET_VAL != 0) ? DC_RUN : DC_IDLE;

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic [WIDTH-1:0] decSum;
    logic [1:0]       stateRaw;
    dc_state_e        state_q;
    dc_state_e        state_d;
    logic             expire_q;
    logic             expire_d;
    logic             decErr_q;
    logic             decErr_d;
    logic             countZero;

    down_counter_reg #(
        .W         (WIDTH),
        .RESET_VAL (RESET_COUNT)
    ) u_count_reg (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (count_d),
        .q_o   (count_q)
    );

    down_counter_reg #(
        .W         (2),
        .RESET_VAL (RESET_STATE)
    ) u_state_reg (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (state_d),
        .q_o   (stateRaw)
    );

    down_counter_adder #(
        .WIDTH (WIDTH)
    ) u_dec_adder (
        .a_i   (count_q),
        .b_i   ({WIDTH{1'b1}}),
        .sum_o (decSum)
    );

    assign state_q   = dc_state_e'(stateRaw);
    assign countZero = (count_q == '0);

    // Next-state logic. Priority is load > dec > ack (reset is handled in the
    // registers). A zero-count dec reports dec_err but still lets ack clear
    // EXPIRED in the same cycle. The unused 2'b11 encoding drops to IDLE with
    // an empty count.
    always_comb begin
        count_d  = count_q;
        state_d  = state_q;
        expire_d = 1'b0;
        decErr_d = 1'b0;

        if ((state_q != ST_IDLE) && (state_q != ST_RUN) && (state_q != ST_EXPIRED)) begin
            count_d = '0;
            state_d = ST_IDLE;
        end else if (load_i) begin
            count_d = load_val_i;
            state_d = (load_val_i != '0) ? ST_RUN : ST_IDLE;
        end else if (dec_i) begin
            count_d  = `DC_SAT_ZERO(countZero, {WIDTH{1'b0}}, decSum);
            decErr_d = countZero;
            if (countZero) begin
                if (ack_i && (state_q == ST_EXPIRED)) begin
                    state_d = ST_IDLE;
                end
            end else if (count_q == WIDTH'(1)) begin
                state_d  = ST_EXPIRED;
                expire_d = 1'b1;
            end
        end else if (ack_i && (state_q == ST_EXPIRED)) begin
            state_d = ST_IDLE;
        end
    end

    // Pulse registers; reset suppresses anything pending.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            expire_q <= 1'b0;
            decErr_q <= 1'b0;
        end else begin
            expire_q <= expire_d;
            decErr_q <= decErr_d;
        end
    end

    assign count_o   = count_q;
    assign busy_o    = (state_q == ST_RUN);
    assign expired_o = (state_q == ST_EXPIRED);
    assign expire_o  = expire_q;
    assign dec_err_o = decErr_q;

endmodule

// File: tb/tb_down_counter.sv
// Directed testbench for down_counter. Two instances share all inputs: one
// with RESET_VAL = 0 and one with RESET_VAL = 5, so both reset rules are seen.

module tb_down_counter;

    logic       clk;
    logic       rst;
    logic       load;
    logic [3:0] loadVal;
    logic       dec;
    logic       ack;

    logic [3:0] count0, count5;
    logic       busy0, busy5;
    logic       expired0, expired5;
    logic       expire0, expire5;
    logic       decErr0, decErr5;

    int errorCount = 0;
    int checkCount = 0;

    down_counter #(.WIDTH(4), .RESET_VAL(0)) dut0 (
        .clk_i      (clk),
        .rst_i      (rst),
        .load_i     (load),
        .load_val_i (loadVal),
        .dec_i      (dec),
        .ack_i      (ack),
        .count_o    (count0),
        .busy_o     (busy0),
        .expired_o  (expired0),
        .expire_o   (expire0),
        .dec_err_o  (decErr0)
    );

    down_counter #(.WIDTH(4), .RESET_VAL(5)) dut5 (
        .clk_i      (clk),
        .rst_i      (rst),
        .load_i     (load),
        .load_val_i (loadVal),
        .dec_i      (dec),
        .ack_i      (ack),
        .count_o    (count5),
        .busy_o     (busy5),
        .expired_o  (expired5),
        .expire_o   (expire5),
        .dec_err_o  (decErr5)
    );

    // Free-running 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs, let the edge happen, and return #1 after it
    // so outputs are sampled away from the edge.
    task automatic applyStimulus(input logic r, input logic l, input logic [3:0] v,
                                 input logic d, input logic a);
        rst     = r;
        load    = l;
        loadVal = v;
        dec     = d;
        ack     = a;
        @(posedge clk);
        #1;
        rst  = 1'b0;
        load = 1'b0;
        dec  = 1'b0;
        ack  = 1'b0;
    endtask

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input int observed, input int expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Directed sequence; expected values are worked out by hand from the
    // counter behaviour (load > dec > ack, saturate at 0, expire on 1->0).
    initial begin
        rst = 1'b0; load = 1'b0; loadVal = 4'd0; dec = 1'b0; ack = 1'b0;
        #2;

        // Reset held two cycles.
        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0);
        checkOutput("rst0 count",   count0,   0);
        checkOutput("rst0 busy",    busy0,    0);
        checkOutput("rst0 expired", expired0, 0);
        checkOutput("rst0 expire",  expire0,  0);
        checkOutput("rst0 decErr",  decErr0,  0);
        checkOutput("rst5 count",   count5,   5);
        checkOutput("rst5 busy",    busy5,    1);
        checkOutput("rst5 expired", expired5, 0);

        // Load 3 then three decrements.
        applyStimulus(0, 1, 3, 0, 0);
        checkOutput("ld3 count", count0, 3);
        checkOutput("ld3 busy",  busy0,  1);
        applyStimulus(0, 0, 0, 1, 0);
        checkOutput("dec1 count",  count0,  2);
        checkOutput("dec1 expire", expire0, 0);
        applyStimulus(0, 0, 0, 1, 0);
        checkOutput("dec2 count",  count0,  1);
        checkOutput("dec2 expire", expire0, 0);
        applyStimulus(0, 0, 0, 1, 0);
        checkOutput("dec3 count",   count0,   0);
        checkOutput("dec3 expire",  expire0,  1);
        checkOutput("dec3 expired", expired0, 1);
        checkOutput("dec3 busy",    busy0,    0);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("hold expire",  expire0,  0);
        checkOutput("hold expired", expired0, 1);
        applyStimulus(0, 0, 0, 0, 1);
        checkOutput("ack expired", expired0, 0);
        checkOutput("ack busy",    busy0,    0);

        // Saturation in IDLE.
        applyStimulus(0, 0, 0, 1, 0);
        checkOutput("sat1 count",  count0,  0);
        checkOutput("sat1 decErr", decErr0, 1);
        checkOutput("sat1 expire", expire0, 0);
        applyStimulus(0, 0, 0, 1, 0);
        checkOutput("sat2 count",  count0,  0);
        checkOutput("sat2 decErr", decErr0, 1);
        checkOutput("sat2 expired", expired0, 0);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("sat idle decErr", decErr0, 0);

        // Load and dec together: dec ignored.
        applyStimulus(0, 1, 7, 1, 0);
        checkOutput("ld7dec count",  count0,  7);
        checkOutput("ld7dec decErr", decErr0, 0);
        checkOutput("ld7dec busy",   busy0,   1);

        // Reach EXPIRED, then load 2 with ack.
        applyStimulus(0, 1, 1, 0, 0);
        applyStimulus(0, 0, 0, 1, 0);
        checkOutput("exp1 expired", expired0, 1);
        applyStimulus(0, 1, 2, 0, 1);
        checkOutput("ld2ack count",   count0,   2);
        checkOutput("ld2ack busy",    busy0,    1);
        checkOutput("ld2ack expired", expired0, 0);

        // Back-to-back: load in the cycle expire is high.
        applyStimulus(0, 1, 1, 0, 0);
        applyStimulus(0, 0, 0, 1, 0);
        checkOutput("b2b expire", expire0, 1);
        applyStimulus(0, 1, 4, 0, 0);
        checkOutput("b2b count",  count0,  4);
        checkOutput("b2b busy",   busy0,   1);
        checkOutput("b2b expire drop", expire0, 0);

        // Full range: 15 down to 0, then one extra dec.
        applyStimulus(0, 1, 15, 0, 0);
        checkOutput("ld15 count", count0, 15);
        for (int i = 1; i <= 15; i++) begin
            applyStimulus(0, 0, 0, 1, 0);
            checkOutput($sformatf("full count %0d", i),  count0,  15 - i);
            checkOutput($sformatf("full expire %0d", i), expire0, (i == 15) ? 1 : 0);
        end
        applyStimulus(0, 0, 0, 1, 0);
        checkOutput("full16 decErr",  decErr0,  1);
        checkOutput("full16 count",   count0,   0);
        checkOutput("full16 expired", expired0, 1);
        // dec_err and ack together: error reported, EXPIRED still cleared.
        applyStimulus(0, 0, 0, 1, 1);
        checkOutput("decack decErr",  decErr0,  1);
        checkOutput("decack expired", expired0, 0);

        // Reset mid-count.
        applyStimulus(0, 1, 9, 0, 0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 0, 0, 1, 0);
        end
        checkOutput("mid count", count0, 5);
        applyStimulus(1, 0, 0, 1, 0);
        checkOutput("midrst0 count",  count0,  0);
        checkOutput("midrst0 busy",   busy0,   0);
        checkOutput("midrst0 expire", expire0, 0);
        checkOutput("midrst5 count",  count5,  5);
        checkOutput("midrst5 busy",   busy5,   1);

        // Reset coinciding with a 1->0 dec suppresses the expire pulse.
        applyStimulus(0, 1, 1, 0, 0);
        applyStimulus(1, 0, 0, 1, 0);
        checkOutput("rstexp expire",  expire0,  0);
        checkOutput("rstexp expired", expired0, 0);
        checkOutput("rstexp5 count",  count5,   5);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

    // Guard against a hung run.
    initial begin
        #100000;
        $display("[TB] FAIL timeout: got 0 expected 1");
        $fatal(1, "[TB] timeout");
    end

endmodule
